// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, FSM states, datapath select
// encodings and the Moore control-word decode used by multicycle_ctrl.
package mips_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned WAIT_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_LOGIC = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_t;

  // Registered control word; ir_write and the FETCH part of pc_write are
  // handshake-dependent and live outside it.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
    logic       trap;
  } ctrl_t;

  // Moore control word for a state; imm_logic picks the logic-immediate ALU
  // op in EXEC_I, wb_rtype picks rd as the WB_ALU destination.
  function automatic ctrl_t moore_ctrl(state_t s, logic imm_logic, logic wb_rtype);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = imm_logic ? ALUOP_LOGIC : ALUOP_ADD;
      end
      ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = wb_rtype;
      end
      WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      TRAP: c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles while a memory
// state is active and flags the cycle on which the wait limit is hit.
module mc_wait_timer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout_c
);

  logic [WAIT_W-1:0] cnt;

  // Count stalled cycles; any exit (ready, timeout, leaving the state) clears.
  always_ff @(posedge clk) begin
    if (reset || !active || mem_ready) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  // Limit reached on this stalled cycle; a simultaneous ready suppresses it.
  assign timeout_c = active && !mem_ready && (cnt == WAIT_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// MIPS multicycle control FSM with memory-wait timeout and a retired
// instruction counter. Optional logic immediates (andi/ori/xori/slti) are
// enabled by defining MC_IMM_LOGIC_EN; otherwise those opcodes trap.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   retire_c;
  logic   timeout_c;
  logic   imm_logic_c;
  logic   wait_active_c;

  // Opcode dispatch out of DECODE.
  function automatic state_t decode_op(logic [5:0] op);
    state_t s;
    case (op)
      OP_RTYPE:      s = EXEC_R;
      OP_ADDI:       s = EXEC_I;
      OP_LW, OP_SW:  s = ADDR;
      OP_BEQ:        s = BRANCH;
      OP_J:          s = JUMP;
`ifdef MC_IMM_LOGIC_EN
      OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: s = EXEC_I;
`endif
      default:       s = TRAP;
    endcase
    return s;
  endfunction

`ifdef MC_IMM_LOGIC_EN
  assign imm_logic_c = (opcode != OP_ADDI);
`else
  assign imm_logic_c = 1'b0;
`endif

  assign wait_active_c = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mc_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .active   (wait_active_c),
    .mem_ready(mem_ready),
    .timeout_c(timeout_c)
  );

  // Next-state and retire decision; ready beats timeout on the limit cycle.
  always_comb begin
    next_state = state;
    retire_c   = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ready)      next_state = DECODE;
        else if (timeout_c) next_state = TRAP;
      end
      DECODE:         next_state = decode_op(opcode);
      EXEC_R, EXEC_I: next_state = WB_ALU;
      ADDR:           next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (mem_ready)      next_state = WB_MEM;
        else if (timeout_c) next_state = TRAP;
      end
      MEM_WR: begin
        if (mem_ready) begin
          next_state = FETCH;
          retire_c   = 1'b1;
        end else if (timeout_c) begin
          next_state = TRAP;
        end
      end
      WB_ALU, WB_MEM, BRANCH, JUMP: begin
        next_state = FETCH;
        retire_c   = 1'b1;
      end
      TRAP:    next_state = TRAP;
      default: next_state = TRAP;
    endcase
  end

  // State, registered Moore control word and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      ctrl_q      <= moore_ctrl(FETCH, 1'b0, 1'b0);
      instr_count <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= moore_ctrl(next_state, imm_logic_c, state == EXEC_R);
      if (retire_c) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign ir_write      = (state == FETCH) && mem_ready && !reset;
  assign pc_write      = ctrl_q.pc_write || ir_write;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign i_or_d        = ctrl_q.i_or_d;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign trap          = ctrl_q.trap;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter MEM_WAIT_MAX, default 15: maximum wait cycles for mem_ready before trapping; legal range 1..255.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port opcode, input, 6: instruction bits [31:26] taken from the instruction register.
REQ-006 Port mem_ready, input, 1: memory completes the current read or write in this cycle.
REQ-007 Port mem_read / mem_write, output, 1 each: memory request, held until mem_ready.
REQ-008 Port i_or_d, output, 1: memory address select; 0 = PC, 1 = ALUOut.
REQ-009 Port ir_write / pc_write / pc_write_cond, output, 1 each: IR load, unconditional PC load, and PC load qualified by zero.
REQ-010 Port reg_dst / mem_to_reg / reg_write / alu_src_a, output, 1 each: datapath selects with the MIPS multicycle meaning.
REQ-011 Port alu_src_b, output, 2: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-012 Port alu_op, output, 2: 00 = add, 01 = sub, 10 = funct-decoded, 11 = immediate-logic.
REQ-013 Port pc_source, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 Port trap, output, 1: sticky; set on an illegal opcode or a memory timeout.
REQ-015 Port instr_count, output, CNT_W: count of retired instructions.

Function
REQ-016 States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP; state register plus a Moore output decode, except ir_write, pc_write and the FETCH exit, which also depend on mem_ready.
REQ-017 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; advance to DECODE on mem_ready.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch-target precompute); next state by opcode:
- 000000 -> EXEC_R
- 001000 -> EXEC_I
- 100011 or 101011 -> ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- any other opcode -> TRAP
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; then WB_ALU with reg_dst=1.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 (ADDI) or 11 (logic immediates); then WB_ALU with reg_dst=0.
REQ-021 WB_ALU: reg_write=1, mem_to_reg=0; retire; then FETCH.
REQ-022 ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; then MEM_RD (lw) or MEM_WR (sw).
REQ-023 MEM_RD: mem_read=1, i_or_d=1; on mem_ready go to WB_MEM, which asserts reg_write=1, mem_to_reg=1, reg_dst=0, retires, then goes to FETCH.
REQ-024 MEM_WR: mem_write=1, i_or_d=1; on mem_ready retire, then FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire; then FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10; retire; then FETCH.
REQ-027 Latency with zero-wait memory:
- R-type, ADDI, sw: 4 cycles
- lw: 5 cycles
- beq, j: 3 cycles
REQ-028 Memory handshake:
- Each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0 increments an 8-bit wait counter; the counter clears when the state is entered.
- If the counter reaches MEM_WAIT_MAX with mem_ready still low, go to TRAP.
- mem_ready in the same cycle as the limit wins: normal advance, no trap.
REQ-029 mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
REQ-030 TRAP: trap=1, all other control outputs 0; TRAP is absorbing until reset.
REQ-031 instr_count increments by 1 per retire and wraps from 2^CNT_W-1 to 0 without flagging.

Reset
REQ-032 On a clk edge with reset=1, the block enters FETCH with wait counter=0, instr_count=0 and trap=0; reset overrides every transition, including mid-memory-wait.
REQ-033 While reset is held, outputs show FETCH's Moore values with ir_write=pc_write=0, regardless of mem_ready.

Configuration
REQ-034 Macro MC_IMM_LOGIC_EN:
- Defined: opcodes 001100, 001101, 001110 and 001010 decode to EXEC_I with alu_op=11.
- Undefined: those opcodes go to TRAP, and alu_op=11 is never driven.

Structure
REQ-035 Package mips_pkg holds the opcode constants, the state enumeration, and the alu_op, alu_src_b and pc_source encodings; the existing control decoder shares the opcode constants.
REQ-036 One sub-module, mc_wait_timer, holds the wait counter and timeout compare.

Verification
REQ-037 Reset then R-type (000000), mem_ready=1 constantly -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 and reg_dst=1 in cycle 4; instr_count=1.
REQ-038 lw (100011) with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d held for 4 cycles; WB_MEM follows with mem_to_reg=1; total 8 cycles.
REQ-039 beq (000100) -> pc_write_cond=1, pc_source=01, alu_op=01 in cycle 3; next cycle is FETCH.
REQ-040 Opcode 111111 -> TRAP after DECODE; trap stays 1 for 20 cycles; reset clears it.
REQ-041 FETCH with mem_ready=0 for MEM_WAIT_MAX cycles -> trap; repeat with mem_ready=1 on the limit cycle -> DECODE, no trap.
REQ-042 Opcode 001101 -> with MC_IMM_LOGIC_EN: EXEC_I, alu_op=11, retire; without it: trap=1.
